data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

- **Role:** data-memory slave on the core's load/store port. Sits directly downstream of the memory stage.
- **Accepts:** one word-addressed access per handshake, using request / we_re / mask / address / store data.
- **Wait states:** inserts a configurable number of wait states, then returns a one-cycle `valid` pulse with the read word.
- **Writes:** performed as byte-lane-masked writes into an internal word array.
- **Result:** load wrapping / sign extension stays in the memory stage, so this block always returns the full aligned 32-bit word.

## Interface
Parameters:
- `DEPTH`, 1024 — number of 32-bit words; must be a power of two.
- `WAIT_CYCLES`, 2 — wait states between acceptance and response; legal range 0–15.

Ports:
- `clk`  in  1  — single clock, all logic rises on `posedge clk`.
- `rst`  in  1  — reset, synchronous and active-high.
- `request`  in  1  — access request; held by the master until `valid`.
- `we_re`  in  1  — 1 = store (write), 0 = load (read).
- `mask`  in  4  — byte-lane enables, bit i ↔ bits [8i+7:8i].
- `address`  in  32  — byte address; bits [1:0] ignored.
- `store_data`  in  32  — write data, lane-aligned.
- `ready`  out  1  — high only in IDLE; request sampled only when high.
- `valid`  out  1  — one-cycle completion pulse.
- `load_data`  out  32  — read word, meaningful when `valid` and the access was a read.
- `err`  out  1  — present only with `DMEM_RANGE_CHECK_EN`; qualifies `valid`.

## Operation
- **FSM states:** IDLE, WAIT, RESP. Wait counter is 4 bits.
- **IDLE:**
  - `ready=1`.
  - On `request=1`, capture `we_re`, `mask`, `address[31:2]` and `store_data` into holding registers.
  - If `WAIT_CYCLES>0`, load counter = `WAIT_CYCLES-1` and go to WAIT; otherwise perform the access and go to RESP.
- **WAIT:**
  - `ready=0`.
  - Decrement the counter each cycle.
  - When the counter reaches 0, perform the access and go to RESP on the same edge.
- **Performing the access:**
  - Write: for each i with `mask[i]=1`, update `mem[idx]` byte i from the captured data.
  - Read: `load_data <= mem[idx]`.
  - `idx = captured_address[log2(DEPTH)+1:2]`.
- **RESP:**
  - `valid=1` for exactly this cycle; `ready=0`.
  - Unconditionally return to IDLE.
- **Write response:** `load_data` is unchanged on writes; `valid` still pulses.
- **Empty write mask:** `mask=4'b0000` on a write leaves the array unchanged and still completes normally.
- **Read mask:** the mask is ignored on reads, and the full word is returned.
- **Input sampling:** inputs are sampled only in IDLE. Changes to inputs during WAIT/RESP have no effect.
- **Next request:** `request` still high in the RESP cycle is not accepted. A new access is taken on the following IDLE cycle.

## Timing
- **Reset values:** `state=IDLE`, `valid=0`, `load_data=0`, `err=0`, counter 0. `ready=1` in the cycle after reset deasserts.
- **Memory array:** not cleared by reset.
- **Latency:** request accepted at edge of cycle N → `valid` high in cycle N+1+`WAIT_CYCLES`.
- **Throughput:** one access per `WAIT_CYCLES+2` cycles.
- **Write visibility:** the write commits on the edge that enters RESP. A read accepted afterwards returns the new data; there is no read-during-write hazard.
- **Reset mid-operation:**
  - `rst` in WAIT drops the pending access; no write is performed and `valid` never pulses.
  - `rst` in RESP forces `valid` low in the next cycle; an already-committed write remains.
- **Address wrap:** without the range check, the address wraps modulo DEPTH words.

## Configuration
- **Macro:** `DMEM_RANGE_CHECK_EN`.
- **Defined:**
  - Adds the `err` port.
  - At acceptance, `address[31:2] >= DEPTH` marks the access out-of-range.
  - Out-of-range writes do not modify the array.
  - Out-of-range reads return `load_data=32'h0`.
  - `err=1` only in the RESP cycle of that access, otherwise 0.
- **Undefined:** no `err` port; upper address bits are discarded (wrap).

## Test plan
- **Reset, then idle:** `rst` held 2 cycles, then released → `ready=1`, `valid=0`, `load_data=0`; no `valid` pulse without a request.
- **Full-word write then read** (`WAIT_CYCLES=2`):
  - Write `32'hDEADBEEF` at `0x40` with mask `4'hF` → `valid` exactly in cycle N+3.
  - Read `0x40` → `load_data=32'hDEADBEEF` in cycle N+3 of the read.
- **Byte-lane write:** memory word `0x40 = 32'hDEADBEEF`; write `32'h00AA0000` mask `4'b0100`; read back → `32'hDEAABEEF`. With `mask=0`, the read returns the word unchanged.
- **Zero wait states** (`WAIT_CYCLES=0`, `request` held high continuously):
  - `valid` in cycle N+1.
  - Next acceptance in cycle N+2; `valid` pulses every 2 cycles.
- **Reset mid-operation:** write issued, `rst` asserted in the first WAIT cycle → no `valid`, and the subsequent read returns the old data.
- **Range check** (`DMEM_RANGE_CHECK_EN`, `DEPTH=1024`):
  - Write to `0x1000` → `err=1` with `valid`.
  - Read of `0x0000` is unchanged.
  - Without the macro, the read of `0x0000` returns the data written to `0x1000` (wrap).

Source files
------------

// File: rtl/data_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Wait-stated word memory slave with byte-lane masked stores.
//            Optional out-of-range detection via macro DMEM_RANGE_CHECK_EN.
// Revision : 1.0
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        ready,
    output logic        valid,
    output logic [31:0] load_data
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int c_idx_w = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [3:0]  r_mask;
    logic [29:0] r_word;
    logic [31:0] r_wdata;
    logic        r_ready;
    logic        r_valid;
    logic [31:0] r_load_data;

    logic [31:0] r_mem [DEPTH];

    logic               w_in_idle;
    logic               w_acc_we;
    logic [3:0]         w_acc_mask;
    logic [29:0]        w_acc_word;
    logic [31:0]        w_acc_wdata;
    logic [c_idx_w-1:0] w_idx;
    logic               w_access;
    logic               w_oor;
    logic               w_mem_wr;
    logic [31:0]        w_rd_word;
    logic               w_unused;

    // With zero wait states the access happens on the accepting edge, so the
    // live inputs stand in for the not-yet-loaded holding registers.
    assign w_in_idle   = (r_state == S_IDLE);
    assign w_acc_we    = w_in_idle ? we_re         : r_we;
    assign w_acc_mask  = w_in_idle ? mask          : r_mask;
    assign w_acc_word  = w_in_idle ? address[31:2] : r_word;
    assign w_acc_wdata = w_in_idle ? store_data    : r_wdata;
    assign w_idx       = w_acc_word[c_idx_w-1:0];

    assign w_access = !rst && (w_in_idle ? (request && (WAIT_CYCLES == 0))
                                         : ((r_state == S_WAIT) && (r_cnt == 4'd0)));

`ifdef DMEM_RANGE_CHECK_EN
    assign w_oor = ((w_acc_word >> c_idx_w) != '0);
`else
    assign w_oor = 1'b0;
`endif

    assign w_mem_wr  = w_access && w_acc_we && !w_oor;
    assign w_rd_word = w_oor ? 32'h0 : r_mem[w_idx];
    assign w_unused  = &{1'b0, address[1:0], w_acc_word};

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_mask      <= 4'd0;
            r_word      <= 30'd0;
            r_wdata     <= 32'd0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_load_data <= 32'd0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (request) begin
                        r_we    <= we_re;
                        r_mask  <= mask;
                        r_word  <= address[31:2];
                        r_wdata <= store_data;
                        r_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
            if (w_access) begin
                r_valid <= 1'b1;
                if (!w_acc_we) begin
                    r_load_data <= w_rd_word;
                end
            end
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_access && w_oor;
        end
    end

    assign err = r_err;
`endif

    assign ready     = r_ready;
    assign valid     = r_valid;
    assign load_data = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Scoreboard bench for data_mem_ctrl (2 and 0 wait-state instances).
// Revision : 1.0
// ============================================================================
module tb_data_mem_ctrl;

    localparam int c_wait0   = 2;
    localparam int c_timeout = 50;

    typedef struct {
        logic        we;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, we0, ready0, valid0;
    logic [3:0]  mask0;
    logic [31:0] addr0, sd0, ld0;
    logic        req1, we1, ready1, valid1;
    logic [3:0]  mask1;
    logic [31:0] addr1, sd1, ld1;
`ifdef DMEM_RANGE_CHECK_EN
    logic        err0, err1;
`endif

    data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(c_wait0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .request    (req0),
        .we_re      (we0),
        .mask       (mask0),
        .address    (addr0),
        .store_data (sd0),
        .ready      (ready0),
        .valid      (valid0),
        .load_data  (ld0)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .err        (err0)
`endif
    );

    data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .request    (req1),
        .we_re      (we1),
        .mask       (mask1),
        .address    (addr1),
        .store_data (sd1),
        .ready      (ready1),
        .valid      (valid1),
        .load_data  (ld1)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .err        (err1)
`endif
    );

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_ld0 = 32'h0;
    logic [31:0] last_ld1 = 32'h0;
    logic [31:0] exp_rd1  = 32'h0;
    int          last_v1 = -1;
    int          pulses1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Scoreboard monitor, 2 wait-state instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid0) begin
            if (q0.size() == 0) begin
                fail_now("dut0 unexpected valid");
            end else begin
                e = q0.pop_front();
                check32("dut0 valid cycle", cyc, e.cyc);
                check32("dut0 load_data", ld0, e.data);
`ifdef DMEM_RANGE_CHECK_EN
                check32("dut0 err", {31'd0, err0}, {31'd0, e.err});
`endif
            end
        end
    end

    // Zero wait-state instance: request is held high, expectations are
    // pushed whenever an acceptance edge is coming.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && req1 && ready1) begin
            e.we   = we1;
            e.data = we1 ? last_ld1 : exp_rd1;
            e.err  = 1'b0;
            e.cyc  = cyc + 1;
            q1.push_back(e);
            if (!we1) last_ld1 = exp_rd1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid1) begin
            if (q1.size() == 0) begin
                fail_now("dut1 unexpected valid");
            end else begin
                e = q1.pop_front();
                check32("dut1 valid cycle", cyc, e.cyc);
                check32("dut1 load_data", ld1, e.data);
            end
            if (last_v1 >= 0) check32("dut1 valid spacing", cyc - last_v1, 32'd2);
            last_v1 = cyc;
            pulses1++;
        end
    end

    // One access on dut0; rst_at=1/2 asserts reset in the 1st/2nd wait cycle.
    task automatic acc0(input logic we, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_err, input int rst_at);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        we0 = we; mask0 = m; addr0 = a; sd0 = d; req0 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready0 && n < c_timeout);
        if (!ready0) begin
            fail_now("dut0 timeout waiting for ready");
            req0 = 1'b0;
            return;
        end
        if (rst_at == 0) begin
            e.we   = we;
            e.data = we ? last_ld0 : exp_rd;
            e.err  = exp_err;
            e.cyc  = cyc + 1 + c_wait0;
            q0.push_back(e);
            if (!we) last_ld0 = exp_rd;
        end
        @(posedge clk); #1;
        {we0, mask0} = 5'($urandom);
        addr0 = $urandom;
        sd0   = $urandom;
        if (rst_at != 0) begin
            if (rst_at == 2) begin @(posedge clk); #1; end
            rst = 1'b1; req0 = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            last_ld0 = 32'h0;
            return;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!valid0 && n < c_timeout);
        if (!valid0) fail_now("dut0 timeout waiting for valid");
        @(posedge clk); #1;
        req0 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; mask0 = 4'h0; addr0 = 32'h0; sd0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; mask1 = 4'h0; addr1 = 32'h0; sd1 = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check32("reset ready", {31'd0, ready0}, 32'd1);
        check32("reset valid", {31'd0, valid0}, 32'd0);
        check32("reset load_data", ld0, 32'h0);
        check32("reset load_data dut1", ld1, 32'h0);
        repeat (5) @(negedge clk);

        acc0(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 32'h0,        1'b0, 0);
        acc0(1'b0, 4'h0, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0, 0);
        acc0(1'b1, 4'h4, 32'h40, 32'h00AA0000, 32'h0,        1'b0, 0);
        acc0(1'b0, 4'hF, 32'h40, 32'h0,        32'hDEAABEEF, 1'b0, 0);
        acc0(1'b1, 4'h0, 32'h40, 32'h12345678, 32'h0,        1'b0, 0);
        acc0(1'b0, 4'h0, 32'h43, 32'h0,        32'hDEAABEEF, 1'b0, 0);
        acc0(1'b1, 4'hF, 32'h44, 32'hA5A5A5A5, 32'h0,        1'b0, 0);
        acc0(1'b1, 4'h9, 32'h44, 32'h11223344, 32'h0,        1'b0, 0);
        acc0(1'b0, 4'h0, 32'h44, 32'h0,        32'h11A5A544, 1'b0, 0);

        // Dropped write: reset in first wait cycle, then in the last one.
        acc0(1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1);
        @(negedge clk);
        check32("mid-op reset ready", {31'd0, ready0}, 32'd1);
        check32("mid-op reset load_data", ld0, 32'h0);
        repeat (6) @(negedge clk);
        acc0(1'b0, 4'h0, 32'h40, 32'h0, 32'hDEAABEEF, 1'b0, 0);
        acc0(1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        repeat (6) @(negedge clk);
        acc0(1'b0, 4'h0, 32'h40, 32'h0, 32'hDEAABEEF, 1'b0, 0);

        acc0(1'b1, 4'hF, 32'h0,    32'h11111111, 32'h0, 1'b0, 0);
`ifdef DMEM_RANGE_CHECK_EN
        acc0(1'b1, 4'hF, 32'h1000, 32'h77777777, 32'h0,        1'b1, 0);
        acc0(1'b0, 4'h0, 32'h0,    32'h0,        32'h11111111, 1'b0, 0);
        acc0(1'b0, 4'h0, 32'h1000, 32'h0,        32'h0,        1'b1, 0);
`else
        acc0(1'b1, 4'hF, 32'h1000, 32'h77777777, 32'h0,        1'b0, 0);
        acc0(1'b0, 4'h0, 32'h0,    32'h0,        32'h77777777, 1'b0, 0);
`endif

        // Zero wait states, request held continuously: 4 writes then 4 reads.
        @(posedge clk); #1;
        we1 = 1'b1; mask1 = 4'hF; addr1 = 32'h10; sd1 = 32'h5A5A5A5A;
        exp_rd1 = 32'h5A5A5A5A;
        req1 = 1'b1;
        repeat (8) @(posedge clk);
        #1 we1 = 1'b0;
        repeat (8) @(posedge clk);
        #1 req1 = 1'b0;

        repeat (10) @(negedge clk);
        check32("dut0 scoreboard drained", q0.size(), 32'd0);
        check32("dut1 scoreboard drained", q1.size(), 32'd0);
        check32("dut1 pulse count", pulses1, 32'd8);
        check32("dut1 last read data", ld1, 32'h5A5A5A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
